pipe_mem_access: RTL

//  Memory-access stage fed directly by the E2->M1 pipeline register; owns the data memory.

---
 rtl/mem_pkg.sv | 30 +++
 rtl/data_ram.sv | 48 ++++
 rtl/pipe_mem_access.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: funct3 access codes,
// writeback source selects and the access-size type.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10
    } mem_size_e;

    // Low two funct3 bits carry the access width; unused codes act as words.
    function automatic mem_size_e size_of(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SIZE_B;
            2'b01:   return SIZE_H;
            default: return SIZE_W;
        endcase
    endfunction

endpackage

// File: rtl/data_ram.sv
// Word-organised data RAM with per-byte write enables and a registered,
// read-first synchronous read port.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          re,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    // Next read word: sample the array (old contents) when enabled, else hold.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    // Read register; cleared on reset so the first extended load is zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    // Byte-lane writes; contents are intentionally not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/pipe_mem_access.sv
// Memory-access stage: turns M1 loads/stores into data RAM accesses, flags
// misaligned accesses, and registers everything into the M2 boundary where
// load data is lane-selected and sign/zero-extended.
module pipe_mem_access
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_m,
    input  logic            reg_write_m1,
    input  logic [1:0]      result_src_m1,
    input  logic            mem_write_m1,
    input  logic [2:0]      funct3_m1,
    input  logic [XLEN-1:0] alu_result_m1,
    input  logic [XLEN-1:0] write_data_m1,
    input  logic [4:0]      rd_m1,
    input  logic [XLEN-1:0] pc_plus4_m1,
    output logic            reg_write_m2,
    output logic [1:0]      result_src_m2,
    output logic [XLEN-1:0] alu_result_m2,
    output logic [XLEN-1:0] read_data_m2,
    output logic [4:0]      rd_m2,
    output logic [XLEN-1:0] pc_plus4_m2,
    output logic            misalign_m2
);

    localparam int AW = $clog2(DEPTH_WORDS);

    mem_size_e   size_m1;
    logic [1:0]  offset_m1;
    logic        is_load_m1;
    logic        misaligned_m1;
    logic [3:0]  byte_en;
    logic [31:0] store_data;
    logic [31:0] ram_rdata;

    logic            reg_write_d,  reg_write_q;
    logic [1:0]      result_src_d, result_src_q;
    logic [XLEN-1:0] alu_result_d, alu_result_q;
    logic [4:0]      rd_d,         rd_q;
    logic [XLEN-1:0] pc_plus4_d,   pc_plus4_q;
    logic            misalign_d,   misalign_q;
    logic [1:0]      offset_d,     offset_q;
    logic [2:0]      funct3_d,     funct3_q;

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Decode the M1 access, check alignment and build store lanes/data.
    always_comb begin
        size_m1       = size_of(funct3_m1);
        offset_m1     = alu_result_m1[1:0];
        is_load_m1    = (result_src_m1 == RES_MEM);
        misaligned_m1 = ((size_m1 == SIZE_H) && offset_m1[0]) ||
                        ((size_m1 == SIZE_W) && (offset_m1 != 2'b00));
        byte_en       = 4'b1111;
        store_data    = write_data_m1;
        case (size_m1)
            SIZE_B: begin
                byte_en    = 4'b0001 << offset_m1;
                store_data = {4{write_data_m1[7:0]}};
            end
            SIZE_H: begin
                byte_en    = offset_m1[1] ? 4'b1100 : 4'b0011;
                store_data = {2{write_data_m1[15:0]}};
            end
            default: begin
                byte_en    = 4'b1111;
                store_data = write_data_m1;
            end
        endcase
        if (!(mem_write_m1 && !stall_m && !rst && !misaligned_m1)) begin
            byte_en = 4'b0000;
        end
    end

    data_ram #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_data_ram (
        .clk  (clk),
        .rst  (rst),
        .re   (!stall_m),
        .we   (byte_en),
        .addr (alu_result_m1[AW+1:2]),
        .wdata(store_data),
        .rdata(ram_rdata)
    );

    // Next M2 values: capture M1 unless stalled, in which case hold.
    always_comb begin
        reg_write_d  = reg_write_q;
        result_src_d = result_src_q;
        alu_result_d = alu_result_q;
        rd_d         = rd_q;
        pc_plus4_d   = pc_plus4_q;
        misalign_d   = misalign_q;
        offset_d     = offset_q;
        funct3_d     = funct3_q;
        if (!stall_m) begin
            reg_write_d  = reg_write_m1 && !(is_load_m1 && misaligned_m1);
            result_src_d = result_src_m1;
            alu_result_d = alu_result_m1;
            rd_d         = rd_m1;
            pc_plus4_d   = pc_plus4_m1;
            misalign_d   = misaligned_m1 && (is_load_m1 || mem_write_m1);
            offset_d     = offset_m1;
            funct3_d     = funct3_m1;
        end
    end

    // M2 register bank; reset wins over stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            reg_write_q  <= 1'b0;
            result_src_q <= '0;
            alu_result_q <= '0;
            rd_q         <= '0;
            pc_plus4_q   <= '0;
            misalign_q   <= 1'b0;
            offset_q     <= '0;
            funct3_q     <= '0;
        end else begin
            reg_write_q  <= reg_write_d;
            result_src_q <= result_src_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
            pc_plus4_q   <= pc_plus4_d;
            misalign_q   <= misalign_d;
            offset_q     <= offset_d;
            funct3_q     <= funct3_d;
        end
    end

    // Select the addressed byte/half of the RAM word and extend it.
    always_comb begin
        case (offset_q)
            2'b00:   load_byte = ram_rdata[7:0];
            2'b01:   load_byte = ram_rdata[15:8];
            2'b10:   load_byte = ram_rdata[23:16];
            default: load_byte = ram_rdata[31:24];
        endcase
        load_half = offset_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];
        case (funct3_q)
            F3_B:    read_data_m2 = {{24{load_byte[7]}}, load_byte};
            F3_BU:   read_data_m2 = {24'h0, load_byte};
            F3_H:    read_data_m2 = {{16{load_half[15]}}, load_half};
            F3_HU:   read_data_m2 = {16'h0, load_half};
            F3_W:    read_data_m2 = ram_rdata;
            default: read_data_m2 = ram_rdata;
        endcase
    end

    assign reg_write_m2  = reg_write_q;
    assign result_src_m2 = result_src_q;
    assign alu_result_m2 = alu_result_q;
    assign rd_m2         = rd_q;
    assign pc_plus4_m2   = pc_plus4_q;
    assign misalign_m2   = misalign_q;

endmodule
